// File: rtl/mux_arb_pkg.sv
// Shared types and select encodings for the two-source round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2
  } state_t;

  typedef enum logic {
    SIDE1 = 1'b0,
    SIDE2 = 1'b1
  } side_t;

  localparam logic SEL_IN1 = 1'b0;
  localparam logic SEL_IN2 = 1'b1;

endpackage

// File: rtl/mux_arbiter_if.sv
// Request/grant handshake and data bus between two sources and the arbiter.
interface mux_arbiter_if #(
  parameter int WIDTH = 1
);
  logic             req1;
  logic             req2;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             gnt1;
  logic             gnt2;
  logic             ctrl;
  logic [WIDTH-1:0] out;
  logic             valid;

  modport master (
    output req1, req2, in1, in2,
    input  gnt1, gnt2, ctrl, out, valid
  );

  modport slave (
    input  req1, req2, in1, in2,
    output gnt1, gnt2, ctrl, out, valid
  );
endinterface

// File: rtl/multiplexer.sv
// 1-bit 2:1 mux cell: ctrl = 0 passes in1, ctrl = 1 passes in2.
module multiplexer (
  output logic out,
  input  logic ctrl,
  input  logic in1,
  input  logic in2
);
  assign out = ctrl ? in2 : in1;
endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter for two sources with a bounded hold time; owns the mux
// select and registers the selected data with a valid qualifier.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  mux_arbiter_if.slave  bus
);

  localparam int                CNT_W    = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0]  HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t             state;
  state_t             nxt;
  side_t              last;
  logic [CNT_W-1:0]   hold_cnt;
  logic               hold_done;
  logic               gnt1_q;
  logic               gnt2_q;
  logic               ctrl_q;
  logic [WIDTH-1:0]   mux_p0;
  logic [WIDTH-1:0]   out_p1;
  logic               vld_p1;

  assign hold_done = (hold_cnt == HOLD_MAX);

  // Releasing the grant takes priority over the hold limit; the limit only
  // forces a handover when the other side is actually waiting.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (bus.req1 && bus.req2)  nxt = (last == SIDE1) ? GRANT2 : GRANT1;
        else if (bus.req1)         nxt = GRANT1;
        else if (bus.req2)         nxt = GRANT2;
        else                       nxt = IDLE;
      end
      GRANT1: begin
        if (!bus.req1)                  nxt = bus.req2 ? GRANT2 : IDLE;
        else if (hold_done && bus.req2) nxt = GRANT2;
        else                            nxt = GRANT1;
      end
      GRANT2: begin
        if (!bus.req2)                  nxt = bus.req1 ? GRANT1 : IDLE;
        else if (hold_done && bus.req1) nxt = GRANT1;
        else                            nxt = GRANT2;
      end
      default: nxt = IDLE;
    endcase
  end

  // Stage p0: combinational select of the granted source, one cell per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    multiplexer u_mux (
      .out  (mux_p0[i]),
      .ctrl (ctrl_q),
      .in1  (bus.in1[i]),
      .in2  (bus.in2[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt1_q   <= 1'b0;
      gnt2_q   <= 1'b0;
      ctrl_q   <= SEL_IN1;
      hold_cnt <= '0;
      last     <= SIDE2;
      out_p1   <= '0;
      vld_p1   <= 1'b0;
    end else begin
      state  <= nxt;
      gnt1_q <= (nxt == GRANT1);
      gnt2_q <= (nxt == GRANT2);

      if (nxt != IDLE && nxt != state) begin
        hold_cnt <= CNT_ONE;
        last     <= (nxt == GRANT2) ? SIDE2 : SIDE1;
        ctrl_q   <= (nxt == GRANT2) ? SEL_IN2 : SEL_IN1;
      end else if (nxt != IDLE && !hold_done) begin
        hold_cnt <= hold_cnt + CNT_ONE;
      end

      // Stage p1: capture the mux output while a grant is active.
      if (state != IDLE) begin
        out_p1 <= mux_p0;
        vld_p1 <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.gnt1  = gnt1_q;
  assign bus.gnt2  = gnt2_q;
  assign bus.ctrl  = ctrl_q;
  assign bus.out   = out_p1;
  assign bus.valid = vld_p1;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter with WIDTH = 8, MAX_HOLD = 4.
module tb_mux_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  mux_arbiter_if #(.WIDTH(8)) bus ();

  mux_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic g1, input logic g2,
                         input logic c, input logic v, input logic [7:0] o);
    chk1({tag, ".gnt1"},  bus.gnt1,  g1);
    chk1({tag, ".gnt2"},  bus.gnt2,  g2);
    chk1({tag, ".ctrl"},  bus.ctrl,  c);
    chk1({tag, ".valid"}, bus.valid, v);
    chk8({tag, ".out"},   bus.out,   o);
  endtask

  // Advance one edge and sample 1 time unit later; grants must never overlap.
  task automatic step();
    @(posedge clk);
    #1;
    chk1("excl", bus.gnt1 & bus.gnt2, 1'b0);
  endtask

  initial begin
    logic g1;
    logic g1p;

    // Reset held two cycles with both sources requesting.
    rst = 1'b1;
    bus.req1 = 1'b1;
    bus.req2 = 1'b1;
    bus.in1  = 8'h11;
    bus.in2  = 8'h22;
    step(); chk_all("rst0", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(); chk_all("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Full contention: 4 cycles each side, strict alternation.
    rst = 1'b0;
    step(); chk_all("con_e1", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int e = 2; e <= 12; e++) begin
      step();
      g1  = (e <= 4) || (e >= 9);
      g1p = ((e - 1) <= 4) || ((e - 1) >= 9);
      chk_all($sformatf("con_e%0d", e), g1, !g1, !g1, 1'b1, g1p ? 8'h11 : 8'h22);
    end

    // Single requester keeps the grant past MAX_HOLD.
    rst = 1'b1;
    step(); chk_all("sgl_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    bus.req2 = 1'b0;
    bus.in1  = 8'hA5;
    for (int e = 1; e <= 10; e++) begin
      step();
      chk_all($sformatf("sgl_e%0d", e), 1'b1, 1'b0, 1'b0, e >= 2, (e >= 2) ? 8'hA5 : 8'h00);
    end

    // Tie from IDLE after source 1 was last granted: source 2 wins.
    bus.req1 = 1'b0;
    step(); chk_all("tie_a", 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
    step(); chk_all("tie_b", 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
    bus.req1 = 1'b1;
    bus.req2 = 1'b1;
    step(); chk_all("tie_c", 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5);
    step(); chk_all("tie_d", 1'b0, 1'b1, 1'b1, 1'b1, 8'h22);

    // Early release after 2 grant cycles; source 2 keeps a full burst.
    rst = 1'b1;
    bus.in1 = 8'h11;
    step(); chk_all("er_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    step(); chk_all("er_e1", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(); chk_all("er_e2", 1'b1, 1'b0, 1'b0, 1'b1, 8'h11);
    bus.req1 = 1'b0;
    step(); chk_all("er_e3", 1'b0, 1'b1, 1'b1, 1'b1, 8'h11);
    bus.req1 = 1'b1;
    step(); chk_all("er_e4", 1'b0, 1'b1, 1'b1, 1'b1, 8'h22);
    step(); chk_all("er_e5", 1'b0, 1'b1, 1'b1, 1'b1, 8'h22);
    step(); chk_all("er_e6", 1'b0, 1'b1, 1'b1, 1'b1, 8'h22);
    step(); chk_all("er_e7", 1'b1, 1'b0, 1'b0, 1'b1, 8'h22);
    step(); chk_all("er_e8", 1'b1, 1'b0, 1'b0, 1'b1, 8'h11);
    step(); chk_all("er_e9", 1'b1, 1'b0, 1'b0, 1'b1, 8'h11);
    step(); chk_all("er_e10", 1'b1, 1'b0, 1'b0, 1'b1, 8'h11);
    step(); chk_all("er_e11", 1'b0, 1'b1, 1'b1, 1'b1, 8'h11);
    step(); chk_all("er_e12", 1'b0, 1'b1, 1'b1, 1'b1, 8'h22);
    step(); chk_all("er_e13", 1'b0, 1'b1, 1'b1, 1'b1, 8'h22);

    // Reset in the third cycle of a gnt2 burst; last returns to source 2.
    rst = 1'b1;
    step(); chk_all("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    step(); chk_all("mid_e1", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(); chk_all("mid_e2", 1'b1, 1'b0, 1'b0, 1'b1, 8'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Two-requester round-robin arbiter that owns the select line of the 2:1 `multiplexer` datapath and shares it between two sources. It grants one requester at a time and holds the grant for at most MAX_HOLD consecutive cycles while the other side is waiting. It drives `ctrl` into the mux and registers the selected data with a `valid` qualifier for the downstream consumer.

## Interface
- WIDTH, 1: data width of `in1`, `in2` and `out`.
- MAX_HOLD, 4: maximum consecutive grant cycles while the other requester waits. Legal range 1..255.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req1  in  1  request from source 1; level-sensitive.
- req2  in  1  request from source 2; level-sensitive.
- in1  in  WIDTH  source 1 data.
- in2  in  WIDTH  source 2 data.
- gnt1  out  1  grant to source 1; registered.
- gnt2  out  1  grant to source 2; registered.
- ctrl  out  1  mux select; registered. 0 selects in1, 1 selects in2.
- out  out  WIDTH  registered mux output.
- valid  out  1  `out` holds granted data.

## Operation
- States: IDLE, GRANT1, GRANT2.
- `gnt1` = (state == GRANT1); `gnt2` = (state == GRANT2). The two grants are never high together.
- `last` flag records the most recently granted side. Reset value is 2, so source 1 wins the first tie.
- `hold_cnt` has width clog2(MAX_HOLD+1). It is set to 1 on entry to any GRANT state.
- IDLE transitions:
  - Both requests high: grant the side opposite `last`.
  - One request high: grant that side.
  - No request: stay in IDLE.
- GRANTx transitions, in priority order:
  1. `reqx` low: go to GRANT(other) if the other side is requesting, else IDLE.
  2. `hold_cnt` == MAX_HOLD and the other side is requesting: go to GRANT(other).
  3. Otherwise stay in GRANTx. `hold_cnt` increments and saturates at MAX_HOLD.
- `last` updates on every GRANT entry.
- `ctrl` follows the granted side. In IDLE it keeps its previous value.
- Datapath:
  - Each edge with state == GRANTx: `out` <= `inx`, `valid` <= 1.
  - Each edge with state == IDLE: `valid` <= 0 and `out` holds.
- Reset values: state IDLE, gnt1 = gnt2 = 0, ctrl = 0, out = 0, valid = 0, hold_cnt = 0, last = 2.

## Timing
- Request to grant: a request sampled at edge N gives a grant visible after edge N.
- Grant to data: data presented while `gnt` is high appears on `out`, with `valid` = 1, after the next edge. The data path latency is 1 cycle.
- Handover: the grant moves directly between sides with no IDLE bubble. `valid` stays high across the switch, and `out` changes source 1 cycle after `ctrl` changes.
- Under continuous contention, each side receives exactly MAX_HOLD grant cycles in strict alternation.
- MAX_HOLD = 1: grants alternate every cycle under contention.
- A request dropped in the same cycle its grant rises still consumes that single grant cycle. Requesters must tolerate this one wasted cycle.
- `rst` high at any edge, including mid-grant: every state and output takes its reset value after that edge, regardless of the requests. Arbitration resumes at the first edge with `rst` low.

## Structure
- Package `mux_arb_pkg`:
  - state typedef: IDLE, GRANT1, GRANT2.
  - select constants SEL_IN1 = 0, SEL_IN2 = 1.
- Sub-module: the datapath uses WIDTH instances of the existing 1-bit `multiplexer` cell, one per bit, via generate. Port order is (out, ctrl, in1, in2). The cell's output feeds the `out` register.
- The FSM, counter and `last` flag stay in `mux_arbiter`.

## Test plan
Cycle numbers count edges after `rst` release; WIDTH = 8, MAX_HOLD = 4.
- Reset with contention: `rst` high 2 cycles with req1 = req2 = 1 -> all outputs 0 during reset. gnt1 = 1, ctrl = 0 after edge 1; out = in1 with valid = 1 after edge 2.
- Single requester: req1 held 10 cycles, req2 = 0, in1 = 0xA5 -> gnt1 high continuously with no switch after MAX_HOLD. out = 0xA5, valid = 1 from edge 2.
- Full contention: req1 = req2 = 1, in1 = 0x11, in2 = 0x22 -> gnt1 on edges 1-4, gnt2 on 5-8, gnt1 on 9-12. ctrl toggles at edges 5 and 9; out switches 0x11 -> 0x22 one cycle later.
- Early release: req1 drops after 2 grant cycles while req2 = 1 -> gnt2 rises at the next edge and keeps the grant a full 4 cycles even if req1 reasserts.
- Tie from IDLE: last grant to source 1, then both deasserted 2 cycles, then both asserted together -> gnt2 wins. `valid` is 0 for the idle cycles.
- Reset mid-grant: `rst` pulsed during cycle 3 of a gnt2 burst -> the next edge gives IDLE, valid = 0, ctrl = 0. With both requesting afterwards, gnt1 wins because `last` was reset.
